// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the pipeline stage register: occupancy state encoding.
package pipe_pkg;

    localparam int PIPE_STATE_W = 2;

    typedef enum logic [PIPE_STATE_W-1:0] {
        PS_EMPTY,
        PS_FULL,
        PS_SKID
    } pipe_state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle between two pipeline stages, plus flush and stall telemetry.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, stall_count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, stall_count
    );
endinterface

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and asynchronous reset to a fixed value.
module pipe_data_reg #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= RESET_DATA;
        else if (load)
            q <= d;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a fully registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0,
    parameter int               CNT_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    pipe_stage_reg_if.slave bus
);
    pipe_state_t      state;
    pipe_state_t      stateNext;
    logic             loadMain;
    logic [WIDTH-1:0] mainD;
    logic [WIDTH-1:0] mainQ;
    logic             inReady;
    logic             outValid;
    logic [CNT_W-1:0] stallCount;

    assign outValid = (state != PS_EMPTY);

`ifdef PIPE_STAGE_SKID_EN
    logic             loadSkid;
    logic [WIDTH-1:0] skidQ;
    logic             inReadyQ;

    // in_ready is the registered image of "next state has a free slot"
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            inReadyQ <= 1'b1;
        else
            inReadyQ <= (stateNext != PS_SKID);
    end

    assign inReady = inReadyQ;
    assign mainD   = (state == PS_SKID) ? skidQ : bus.in_data;

    pipe_data_reg #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) uSkid (
        .clk   (clk),
        .reset (reset),
        .load  (loadSkid),
        .d     (bus.in_data),
        .q     (skidQ)
    );
`else
    assign inReady = (state == PS_EMPTY) || bus.out_ready;
    assign mainD   = bus.in_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= PS_EMPTY;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        loadMain  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        loadSkid  = 1'b0;
`endif
        case (state)
            PS_EMPTY: begin
                if (bus.in_valid) begin
                    stateNext = PS_FULL;
                    loadMain  = 1'b1;
                end
            end
            PS_FULL: begin
                if (bus.out_ready) begin
                    if (bus.in_valid)
                        loadMain = 1'b1;
                    else
                        stateNext = PS_EMPTY;
                end
`ifdef PIPE_STAGE_SKID_EN
                else if (bus.in_valid) begin
                    stateNext = PS_SKID;
                    loadSkid  = 1'b1;
                end
`endif
            end
`ifdef PIPE_STAGE_SKID_EN
            PS_SKID: begin
                if (bus.out_ready) begin
                    stateNext = PS_FULL;
                    loadMain  = 1'b1;
                end
            end
`endif
            default: stateNext = PS_EMPTY;
        endcase
        // Squash drops the valid state and any incoming word; held data stays put
        if (bus.flush) begin
            stateNext = PS_EMPTY;
            loadMain  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            loadSkid  = 1'b0;
`endif
        end
    end

    pipe_data_reg #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) uMain (
        .clk   (clk),
        .reset (reset),
        .load  (loadMain),
        .d     (mainD),
        .q     (mainQ)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stallCount <= '0;
        else if (outValid && !bus.out_ready && (stallCount != {CNT_W{1'b1}}))
            stallCount <= stallCount + 1'b1;
    end

    assign bus.in_ready    = inReady;
    assign bus.out_valid   = outValid;
    assign bus.out_data    = mainQ;
    assign bus.stall_count = stallCount;
endmodule
